// File: rtl/rc5_key_loader_if.sv
// rc5_key_loader_if: key byte stream, key/L RAM write ports and expander handshake
interface rc5_key_loader_if #(
  parameter int W = 16,
  parameter int B = 16
);
  localparam int B_LENGTH = $clog2(B);
  localparam int C_LENGTH = $clog2(B / (W / 8));
  logic                load;
  logic [7:0]          key_byte;
  logic                key_valid;
  logic                key_ready;
  logic [B_LENGTH-1:0] key_address;
  logic [7:0]          key_data;
  logic                key_we;
  logic [C_LENGTH-1:0] l_address;
  logic [W-1:0]        l_data;
  logic                l_we;
  logic                expander_done;
  logic                start_expander;
  logic                busy;
  modport master (
    output load, key_byte, key_valid, expander_done,
    input  key_ready, key_address, key_data, key_we, l_address, l_data, l_we, start_expander, busy
  );
  modport slave (
    input  load, key_byte, key_valid, expander_done,
    output key_ready, key_address, key_data, key_we, l_address, l_data, l_we, start_expander, busy
  );
endinterface

// File: rtl/rc5_key_loader.sv
// rc5_key_loader: streams RC5 key bytes into key RAM and launches the expander; RC5_LPACK_EN also packs L words
module rc5_key_loader #(
  parameter int W = 16,
  parameter int B = 16
) (
  input logic           clk,
  input logic           rst,
  rc5_key_loader_if.slave bus
);
  localparam int B_LENGTH = $clog2(B);
  typedef enum logic [2:0] {IDLE, LOAD, FLUSH, START, WAIT_EXP} state_t;
  state_t state, next;
  logic [B_LENGTH:0] cnt;
  logic accept, last, restart;
  assign accept  = state == LOAD && bus.key_valid && !bus.load;
  assign last    = cnt == (B_LENGTH+1)'(B - 1);
  assign restart = bus.load && (state == IDLE || state == LOAD);
  assign bus.key_ready      = state == LOAD;
  assign bus.start_expander = state == START;
  assign bus.busy           = state != IDLE;
  // state register
  always_ff @(posedge clk)
    state <= rst ? IDLE : next;
  // next-state logic; iLoad restarts a session from IDLE or LOAD, never from the tail states
  always_comb begin
    next = state;
    case (state)
      IDLE:     next = bus.load ? LOAD : IDLE;
      LOAD:     next = bus.load ? LOAD : (accept && last) ? FLUSH : LOAD;
      FLUSH:    next = START;
      START:    next = WAIT_EXP;
      WAIT_EXP: next = bus.expander_done ? IDLE : WAIT_EXP;
      default:  next = IDLE;
    endcase
  end
  // byte counter and registered key RAM write strobe
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt             <= '0;
      bus.key_we      <= 1'b0;
      bus.key_address <= '0;
      bus.key_data    <= '0;
    end else begin
      cnt        <= restart ? '0 : accept ? cnt + 1'b1 : cnt;
      bus.key_we <= accept;
      if (accept) begin
        bus.key_address <= cnt[B_LENGTH-1:0];
        bus.key_data    <= bus.key_byte;
      end
    end
  end
`ifdef RC5_LPACK_EN
  localparam int U        = W / 8;
  localparam int LB       = $clog2(U);
  localparam int C_LENGTH = $clog2(B / U);
  logic [W-1:0]  pack, pack_next;
  logic [LB-1:0] lane;
  assign lane      = cnt[LB-1:0];
  assign pack_next = pack | (W'(bus.key_byte) << {lane, 3'b000});
  // little-endian word packing; a completed word is written alongside its last byte's key write
  always_ff @(posedge clk) begin
    if (rst) begin
      pack          <= '0;
      bus.l_we      <= 1'b0;
      bus.l_address <= '0;
      bus.l_data    <= '0;
    end else begin
      pack     <= restart ? '0 : accept ? (&lane ? '0 : pack_next) : pack;
      bus.l_we <= accept && &lane;
      if (accept && &lane) begin
        bus.l_address <= C_LENGTH'(cnt >> LB);
        bus.l_data    <= pack_next;
      end
    end
  end
`else
  assign bus.l_we      = 1'b0;
  assign bus.l_address = '0;
  assign bus.l_data    = {W{1'b0}};
`endif
endmodule

// File: tb/tb_rc5_key_loader.sv
// tb_rc5_key_loader: scoreboard bench for rc5_key_loader (define RC5_LPACK_EN to expect L writes)
module tb_rc5_key_loader;
  localparam int W = 16;
  localparam int B = 16;
  localparam int U = W / 8;
  typedef struct {int addr; int data; int cyc;} wr_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  rc5_key_loader_if #(.W(W), .B(B)) bus();
  rc5_key_loader #(.W(W), .B(B)) dut (.clk(clk), .rst(rst), .bus(bus));
  wr_t kq[$];
  wr_t lq[$];
  int sq[$];
  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;
  int k = 0;
  logic [W-1:0] word = '0;
  logic [7:0] ram [B];
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic new_session();
    k = 0;
    word = '0;
  endtask
  task automatic do_load();
    bus.load = 1'b1;
    step();
    bus.load = 1'b0;
    new_session();
  endtask
  task automatic send(input logic [7:0] b, input bit last);
    bus.key_byte = b;
    bus.key_valid = 1'b1;
    step();
    bus.key_valid = 1'b0;
    kq.push_back('{k, int'(b), cyc});
`ifdef RC5_LPACK_EN
    word = word | (W'(b) << (8 * (k % U)));
    if (k % U == U - 1) begin
      lq.push_back('{k / U, int'(word), cyc});
      word = '0;
    end
`endif
    if (last) sq.push_back(cyc + 1);
    k++;
  endtask
  task automatic wait_exp(input bit harass);
    step();
    step();
    chk("wait_ready", bus.key_ready, 0);
    chk("wait_busy", bus.busy, 1);
    if (harass) begin
      bus.load = 1'b1;
      bus.key_valid = 1'b1;
      bus.key_byte = 8'h77;
      step();
      step();
      chk("wait_ready_harass", bus.key_ready, 0);
      chk("wait_busy_harass", bus.busy, 1);
      bus.load = 1'b0;
      bus.key_valid = 1'b0;
    end
    bus.expander_done = 1'b1;
    step();
    bus.expander_done = 1'b0;
    chk("done_busy", bus.busy, 0);
    chk("done_ready", bus.key_ready, 0);
  endtask
  // scoreboard monitor: every strobe must match the oldest expectation, including its cycle
  always @(negedge clk) begin : monitor
    wr_t e;
    if (bus.key_we === 1'b1) begin
      if (kq.size() == 0) chk("key_we_unexpected", 1, 0);
      else begin
        e = kq.pop_front();
        chk("key_addr", 64'(bus.key_address), 64'(e.addr));
        chk("key_data", 64'(bus.key_data), 64'(e.data));
        chk("key_cycle", 64'(cyc), 64'(e.cyc));
        ram[bus.key_address] = bus.key_data;
      end
    end
    if (bus.l_we === 1'b1) begin
      if (lq.size() == 0) chk("l_we_unexpected", 1, 0);
      else begin
        e = lq.pop_front();
        chk("l_addr", 64'(bus.l_address), 64'(e.addr));
        chk("l_data", 64'(bus.l_data), 64'(e.data));
        chk("l_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
    if (bus.start_expander === 1'b1) begin
      if (sq.size() == 0) chk("start_unexpected", 1, 0);
      else chk("start_cycle", 64'(cyc), 64'(sq.pop_front()));
    end
  end
  initial begin
    bus.load = 1'b0;
    bus.key_byte = '0;
    bus.key_valid = 1'b0;
    bus.expander_done = 1'b0;
    repeat (3) step();
    chk("rst_key_we", bus.key_we, 0);
    chk("rst_ready", bus.key_ready, 0);
    chk("rst_start", bus.start_expander, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_l_we", bus.l_we, 0);
    chk("rst_key_addr", 64'(bus.key_address), 0);
    chk("rst_l_data", 64'(bus.l_data), 0);
    rst = 1'b0;
    step();
    bus.key_valid = 1'b1;
    bus.key_byte = 8'h55;
    step();
    chk("idle_ignores_valid", bus.busy, 0);
    bus.load = 1'b1;
    step();
    bus.load = 1'b0;
    bus.key_valid = 1'b0;
    new_session();
    chk("load_busy", bus.busy, 1);
    chk("load_ready", bus.key_ready, 1);
    for (int i = 0; i < B; i++) send(8'(i), i == B - 1);
    wait_exp(1'b1);
    do_load();
    for (int i = 0; i < B; i++) begin
      send(8'(8'h30 + i), i == B - 1);
      if (i % 3 == 0 && i != B - 1) begin
        step();
        step();
      end
    end
    wait_exp(1'b0);
    do_load();
    for (int i = 0; i < 5; i++) send(8'(8'h10 + i), 1'b0);
    bus.load = 1'b1;
    bus.key_valid = 1'b1;
    bus.key_byte = 8'hEE;
    step();
    bus.load = 1'b0;
    bus.key_valid = 1'b0;
    new_session();
    for (int i = 0; i < B; i++) send(8'(8'hA0 + i), i == B - 1);
    wait_exp(1'b0);
    for (int i = 0; i < B; i++) chk($sformatf("ram_%0d", i), 64'(ram[i]), 64'(8'hA0 + i));
    do_load();
    for (int i = 0; i < 9; i++) send(8'(8'h60 + i), 1'b0);
    rst = 1'b1;
    bus.key_valid = 1'b1;
    bus.key_byte = 8'h69;
    step();
    rst = 1'b0;
    bus.key_valid = 1'b0;
    chk("mid_rst_key_we", bus.key_we, 0);
    chk("mid_rst_l_we", bus.l_we, 0);
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_ready", bus.key_ready, 0);
    chk("mid_rst_start", bus.start_expander, 0);
    chk("mid_rst_key_data", 64'(bus.key_data), 0);
    repeat (3) step();
    do_load();
    for (int i = 0; i < B; i++) send(8'(8'hC0 + i), i == B - 1);
    wait_exp(1'b0);
    repeat (3) step();
    chk("key_queue_drained", 64'(kq.size()), 0);
    chk("l_queue_drained", 64'(lq.size()), 0);
    chk("start_queue_drained", 64'(sq.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
